// File: rtl/sys_defs.sv
// Shared bus and tag definitions for the memory arbiter and its tag table.
package sys_defs;
  localparam int XLEN     = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;  // tag 0 means "none", so 15 usable tags

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_command_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   squashed;
  } tag_entry_t;
endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory tags 1..15: allocate on load accept,
// look up and clear on return, squash fetch-owned entries on flush.
module mem_tag_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  tag_t       alloc_tag,
  input  owner_t     alloc_owner,
  input  tag_t       lookup_tag,
  input  logic       clear_en,
  output tag_entry_t lookup_entry,
  input  logic       flush
);
  tag_entry_t entries [1:NUM_TAGS-1];

  always_comb begin
    lookup_entry = '0;
    if (lookup_tag != '0) lookup_entry = entries[lookup_tag];
  end

  // NOTE: every entry is reset; a stale valid bit would misroute a later
  // return, so this table must stay flops with a reset rather than a RAM.
  always_ff @(posedge clock) begin
    for (int i = 1; i < NUM_TAGS; i++) begin
      if (reset) begin
        entries[i] <= '0;
      end else begin
        if (clear_en && lookup_tag == tag_t'(i)) entries[i].valid <= 1'b0;
        if (flush && entries[i].valid && entries[i].owner == OWN_IC)
          entries[i].squashed <= 1'b1;
        // NOTE: the last non-blocking assignment to a flop in a block wins,
        // so a same-cycle allocation overrides both clear and squash.
        if (alloc_en && alloc_tag == tag_t'(i))
          entries[i] <= '{valid: 1'b1, owner: alloc_owner, squashed: 1'b0};
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one tagged memory port and routes
// returned data back to the requester recorded in the tag table.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ic_req_valid,
  input  logic [XLEN-1:0]    ic_req_addr,
  input  logic               ic_flush,
  input  bus_command_t       dc_req_cmd,
  input  logic [XLEN-1:0]    dc_req_addr,
  input  logic [63:0]        dc_req_data,
  input  tag_t               mem2proc_response,
  input  logic [63:0]        mem2proc_data,
  input  tag_t               mem2proc_tag,
  output bus_command_t       proc2mem_command,
  output logic [XLEN-1:0]    proc2mem_addr,
  output logic [63:0]        proc2mem_data,
  output logic               ic_grant,
  output logic               dc_grant,
  output tag_t               ic_req_tag,
  output tag_t               dc_req_tag,
  output logic               ic_resp_valid,
  output tag_t               ic_resp_tag,
  output logic [63:0]        ic_resp_data,
  output logic               dc_resp_valid,
  output tag_t               dc_resp_tag,
  output logic [63:0]        dc_resp_data,
  output logic               spurious_resp
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             ic_priority, dc_active, ic_sel, dc_sel, accepted;
  logic             ret_valid, ret_hit;
  tag_entry_t       ret_entry;

  assign ic_priority = (starve_cnt == STARVE_MAX);
  assign dc_active   = (dc_req_cmd != BUS_NONE);
  assign ic_sel      = !reset && ic_req_valid && (ic_priority || !dc_active);
  assign dc_sel      = !reset && dc_active && !ic_sel;
  assign accepted    = (mem2proc_response != '0);

  assign ic_grant   = ic_sel && accepted;
  assign dc_grant   = dc_sel && accepted;
  assign ic_req_tag = ic_grant ? mem2proc_response : '0;
  assign dc_req_tag = dc_grant ? mem2proc_response : '0;

  // NOTE: every output gets a default before the branches, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (ic_sel) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_req_addr;
    end else if (dc_sel) begin
      proc2mem_command = dc_req_cmd;
      proc2mem_addr    = dc_req_addr;
      if (dc_req_cmd == BUS_STORE) proc2mem_data = dc_req_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !ic_req_valid || ic_grant) starve_cnt <= '0;
    else if (!ic_priority)                   starve_cnt <= starve_cnt + 1'b1;
  end

  // Returns seen during reset are ignored entirely, including the spurious flag.
  assign ret_valid     = !reset && (mem2proc_tag != '0);
  assign ret_hit       = ret_valid && ret_entry.valid;
  assign spurious_resp = ret_valid && !ret_entry.valid;

  assign ic_resp_valid = ret_hit && ret_entry.owner == OWN_IC && !ret_entry.squashed && !ic_flush;
  assign dc_resp_valid = ret_hit && ret_entry.owner == OWN_DC;
  assign ic_resp_tag   = ic_resp_valid ? mem2proc_tag  : '0;
  assign ic_resp_data  = ic_resp_valid ? mem2proc_data : '0;
  assign dc_resp_tag   = dc_resp_valid ? mem2proc_tag  : '0;
  assign dc_resp_data  = dc_resp_valid ? mem2proc_data : '0;

  mem_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (ic_grant || (dc_grant && dc_req_cmd == BUS_LOAD)),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (ic_grant ? OWN_IC : OWN_DC),
    .lookup_tag   (mem2proc_tag),
    .clear_en     (ret_hit),
    .lookup_entry (ret_entry),
    .flush        (ic_flush)
  );
endmodule
